muldiv_unit: RTL and testbench

- Standalone iterative multiply/divide engine, parametrised in operand width, with signed and unsigned modes.
- Replaces the in-datapath MW/DW microcode loops. The CPU hands it one request and collects a double-width result over a valid/ready handshake.
- Divide-by-zero and quotient overflow are reported explicitly.
- Sits beside the CPU register file; the CPU writes resp_hi/resp_lo back to the register pair R and R|1.

---
 rtl/muldiv_unit_if.sv | 28 ++
 rtl/muldiv_unit.sv | 210 +++++++++++++++++++++
 tb/tb_muldiv_unit.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the CPU and the iterative multiply/divide unit.
// The CPU side is the master; the arithmetic unit is the slave.
interface muldiv_unit_if #(
    parameter int WIDTH = 32
);
    logic             req_valid;
    logic             req_ready;
    logic [1:0]       req_op;
    logic [WIDTH-1:0] req_hi;
    logic [WIDTH-1:0] req_lo;
    logic [WIDTH-1:0] req_operand;
    logic             resp_valid;
    logic             resp_ready;
    logic [WIDTH-1:0] resp_hi;
    logic [WIDTH-1:0] resp_lo;
    logic             resp_dz;
    logic             resp_ovf;

    modport master (
        output req_valid, req_op, req_hi, req_lo, req_operand, resp_ready,
        input  req_ready, resp_valid, resp_hi, resp_lo, resp_dz, resp_ovf
    );

    modport slave (
        input  req_valid, req_op, req_hi, req_lo, req_operand, resp_ready,
        output req_ready, resp_valid, resp_hi, resp_lo, resp_dz, resp_ovf
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide engine.
// Multiply: radix-4 Booth over the operand extended to WIDTH+2 bits, WIDTH/2+1 digits.
// Divide: one set-up cycle (operand magnitudes, early overflow test), WIDTH
// non-restoring steps, then one fix-up cycle for remainder correction and signs.
// A zero divisor skips the loop and is reported from the fix-up cycle.
module muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNTW  = 8
) (
    input  logic         clock,
    input  logic         reset,
    muldiv_unit_if.slave bus
);
    localparam int EXTW = WIDTH + 2;
    localparam int ACCW = WIDTH + 4;

    typedef enum logic [2:0] {IDLE, MUL_LOOP, DIV_LOOP, DIV_FIX, DONE} state_t;

    state_t           state_q, state_d;
    logic [CNTW-1:0]  cnt_q;
    logic [ACCW-1:0]  acc_q;
    logic [EXTW-1:0]  mq_q;
    logic [EXTW-1:0]  b_q;
    logic             booth_q;
    logic             signed_q;
    logic             dvd_neg_q;
    logic             dsr_neg_q;
    logic             ovf_pend_q;
    logic             dz_pend_q;
    logic [WIDTH-1:0] orig_hi_q;
    logic [WIDTH-1:0] orig_lo_q;
    logic [WIDTH-1:0] resp_hi_q;
    logic [WIDTH-1:0] resp_lo_q;
    logic             resp_dz_q;
    logic             resp_ovf_q;

    logic accept, req_is_div, req_signed, req_zero, cnt_zero, div_prep;

    assign accept     = bus.req_valid && (state_q == IDLE);
    assign req_is_div = bus.req_op[0];
    assign req_signed = ~bus.req_op[1];
    assign req_zero   = (bus.req_operand == '0);
    assign cnt_zero   = (cnt_q == '0);
    assign div_prep   = (cnt_q == CNTW'(WIDTH));

    assign bus.req_ready  = (state_q == IDLE);
    assign bus.resp_valid = (state_q == DONE);
    assign bus.resp_hi    = resp_hi_q;
    assign bus.resp_lo    = resp_lo_q;
    assign bus.resp_dz    = resp_dz_q;
    assign bus.resp_ovf   = resp_ovf_q;

    // Booth step: two guard bits above the extended operand keep +-2A from overflowing
    logic [ACCW-1:0] b_ext, booth_pp, mul_sum, mul_acc_next;
    logic [EXTW-1:0] mul_mq_next;
    logic [WIDTH-1:0] mul_hi, mul_lo;

    assign b_ext = {{(ACCW-EXTW){b_q[EXTW-1]}}, b_q};

    // Select the partial product from the current radix-4 Booth digit
    always_comb begin
        booth_pp = '0;
        case ({mq_q[1:0], booth_q})
            3'b001, 3'b010: booth_pp = b_ext;
            3'b011:         booth_pp = b_ext << 1;
            3'b100:         booth_pp = -(b_ext << 1);
            3'b101, 3'b110: booth_pp = -b_ext;
            default:        booth_pp = '0;
        endcase
    end

    assign mul_sum      = acc_q + booth_pp;
    assign mul_acc_next = {{2{mul_sum[ACCW-1]}}, mul_sum[ACCW-1:2]};
    assign mul_mq_next  = {mul_sum[1:0], mq_q[EXTW-1:2]};
    assign mul_hi       = {mul_acc_next[WIDTH-3:0], mul_mq_next[EXTW-1:WIDTH]};
    assign mul_lo       = mul_mq_next[WIDTH-1:0];

    // Divide works on magnitudes; signs are reapplied in the fix-up cycle
    logic [2*WIDTH-1:0] dvd_abs;
    logic [WIDTH-1:0]   dsr_abs, quo_mag, rem_mag;
    logic [ACCW-1:0]    div_shift, div_next;
    logic               quo_neg, quo_too_big, div_ovf;

    assign dvd_abs     = dvd_neg_q ? -{orig_hi_q, orig_lo_q} : {orig_hi_q, orig_lo_q};
    assign dsr_abs     = dsr_neg_q ? -b_q[WIDTH-1:0] : b_q[WIDTH-1:0];
    assign div_shift   = {acc_q[ACCW-2:0], mq_q[WIDTH-1]};
    assign div_next    = acc_q[ACCW-1] ? div_shift + b_ext : div_shift - b_ext;
    assign quo_mag     = mq_q[WIDTH-1:0];
    assign rem_mag     = acc_q[ACCW-1] ? acc_q[WIDTH-1:0] + b_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    assign quo_neg     = dvd_neg_q ^ dsr_neg_q;
    assign quo_too_big = quo_neg ? (quo_mag[WIDTH-1] && (quo_mag[WIDTH-2:0] != '0))
                                 : quo_mag[WIDTH-1];
    assign div_ovf     = ovf_pend_q || (signed_q && quo_too_big);

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state decision
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (!req_is_div)   state_d = MUL_LOOP;
                    else if (req_zero) state_d = DIV_FIX;
                    else               state_d = DIV_LOOP;
                end
            end
            MUL_LOOP: if (cnt_zero) state_d = DONE;
            DIV_LOOP: if (cnt_zero) state_d = DIV_FIX;
            DIV_FIX:  state_d = DONE;
            DONE:     if (bus.resp_ready) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Datapath: operand capture, iteration, and result registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q      <= '0;
            acc_q      <= '0;
            mq_q       <= '0;
            b_q        <= '0;
            booth_q    <= 1'b0;
            signed_q   <= 1'b0;
            dvd_neg_q  <= 1'b0;
            dsr_neg_q  <= 1'b0;
            ovf_pend_q <= 1'b0;
            dz_pend_q  <= 1'b0;
            orig_hi_q  <= '0;
            orig_lo_q  <= '0;
            resp_hi_q  <= '0;
            resp_lo_q  <= '0;
            resp_dz_q  <= 1'b0;
            resp_ovf_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        signed_q   <= req_signed;
                        orig_hi_q  <= bus.req_hi;
                        orig_lo_q  <= bus.req_lo;
                        acc_q      <= '0;
                        booth_q    <= 1'b0;
                        ovf_pend_q <= 1'b0;
                        dz_pend_q  <= req_is_div && req_zero;
                        dvd_neg_q  <= req_is_div && req_signed && bus.req_hi[WIDTH-1];
                        dsr_neg_q  <= req_is_div && req_signed && bus.req_operand[WIDTH-1];
                        if (!req_is_div) begin
                            b_q   <= {{2{req_signed & bus.req_lo[WIDTH-1]}}, bus.req_lo};
                            mq_q  <= {{2{req_signed & bus.req_operand[WIDTH-1]}}, bus.req_operand};
                            cnt_q <= CNTW'(WIDTH / 2);
                        end else begin
                            b_q   <= {2'b00, bus.req_operand};
                            mq_q  <= '0;
                            cnt_q <= CNTW'(WIDTH);
                        end
                    end
                end
                MUL_LOOP: begin
                    acc_q   <= mul_acc_next;
                    mq_q    <= mul_mq_next;
                    booth_q <= mq_q[1];
                    if (cnt_zero) begin
                        resp_hi_q <= mul_hi;
                        resp_lo_q <= mul_lo;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                DIV_LOOP: begin
                    if (div_prep) begin
                        acc_q      <= {{(ACCW-WIDTH){1'b0}}, dvd_abs[2*WIDTH-1:WIDTH]};
                        mq_q       <= {2'b00, dvd_abs[WIDTH-1:0]};
                        b_q        <= {2'b00, dsr_abs};
                        ovf_pend_q <= (dvd_abs[2*WIDTH-1:WIDTH] >= dsr_abs);
                    end else begin
                        acc_q <= div_next;
                        mq_q  <= {2'b00, mq_q[WIDTH-2:0], ~div_next[ACCW-1]};
                    end
                    if (!cnt_zero) cnt_q <= cnt_q - 1'b1;
                end
                DIV_FIX: begin
                    if (dz_pend_q) begin
                        resp_hi_q <= orig_hi_q;
                        resp_lo_q <= orig_lo_q;
                        resp_dz_q <= 1'b1;
                    end else if (div_ovf) begin
                        resp_hi_q  <= orig_hi_q;
                        resp_lo_q  <= orig_lo_q;
                        resp_ovf_q <= 1'b1;
                    end else begin
                        resp_lo_q <= quo_neg ? -quo_mag : quo_mag;
                        resp_hi_q <= dvd_neg_q ? -rem_mag : rem_mag;
                    end
                end
                DONE: begin
                    if (bus.resp_ready) begin
                        resp_dz_q  <= 1'b0;
                        resp_ovf_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed checks on a 32-bit unit plus randomised checks on an 8-bit unit
// against a plain integer reference.
module tb_muldiv_unit;
    logic clock = 1'b0;
    logic reset;

    always #5 clock = ~clock;

    muldiv_unit_if #(.WIDTH(32)) bus32 ();
    muldiv_unit_if #(.WIDTH(8))  bus8 ();

    muldiv_unit #(.WIDTH(32), .CNTW(8)) u32 (.clock(clock), .reset(reset), .bus(bus32));
    muldiv_unit #(.WIDTH(8),  .CNTW(4)) u8  (.clock(clock), .reset(reset), .bus(bus8));

    int checks = 0;
    int errors = 0;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Present a request on the 32-bit unit, wait for acceptance, then count edges to resp_valid
    task automatic applyStimulus(input logic [1:0] op, input logic [31:0] hi, input logic [31:0] lo,
                                 input logic [31:0] opnd, output int latency, output int waited);
        bus32.req_op      = op;
        bus32.req_hi      = hi;
        bus32.req_lo      = lo;
        bus32.req_operand = opnd;
        bus32.req_valid   = 1'b1;
        waited = 0;
        while (bus32.req_ready !== 1'b1 && waited < 50) begin
            @(posedge clock); #1;
            waited++;
        end
        @(posedge clock); #1;
        bus32.req_valid = 1'b0;
        latency = 0;
        while (bus32.resp_valid !== 1'b1 && latency < 200) begin
            @(posedge clock); #1;
            latency++;
        end
    endtask

    task automatic applySmall(input logic [1:0] op, input logic [7:0] hi, input logic [7:0] lo,
                              input logic [7:0] opnd, output int latency);
        int waited;
        bus8.req_op      = op;
        bus8.req_hi      = hi;
        bus8.req_lo      = lo;
        bus8.req_operand = opnd;
        bus8.req_valid   = 1'b1;
        waited = 0;
        while (bus8.req_ready !== 1'b1 && waited < 50) begin
            @(posedge clock); #1;
            waited++;
        end
        @(posedge clock); #1;
        bus8.req_valid = 1'b0;
        latency = 0;
        while (bus8.resp_valid !== 1'b1 && latency < 100) begin
            @(posedge clock); #1;
            latency++;
        end
    endtask

    task automatic checkResp32(input string tag, input int latency, input int exp_lat,
                               input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                               input logic exp_dz, input logic exp_ovf);
        checkOutput({tag, " latency"}, 64'(latency), 64'(exp_lat));
        checkOutput({tag, " hi/lo"}, {bus32.resp_hi, bus32.resp_lo}, {exp_hi, exp_lo});
        checkOutput({tag, " dz/ovf"}, {62'b0, bus32.resp_dz, bus32.resp_ovf}, {62'b0, exp_dz, exp_ovf});
    endtask

    // Integer reference for the 8-bit unit: {hi, lo, dz, ovf}
    function automatic logic [17:0] refModel(input logic [1:0] op, input logic [7:0] hi,
                                             input logic [7:0] lo, input logic [7:0] d);
        longint a, b, n, q, r, p;
        logic sgn;
        sgn = ~op[1];
        if (!op[0]) begin
            a = sgn ? longint'($signed(lo)) : longint'(lo);
            b = sgn ? longint'($signed(d))  : longint'(d);
            p = a * b;
            return {p[15:0], 2'b00};
        end
        if (d == 8'd0) return {hi, lo, 2'b10};
        n = sgn ? longint'($signed({hi, lo})) : longint'({hi, lo});
        b = sgn ? longint'($signed(d)) : longint'(d);
        q = n / b;
        r = n % b;
        if (sgn ? (q > 127 || q < -128) : (q > 255)) return {hi, lo, 2'b01};
        return {r[7:0], q[7:0], 2'b00};
    endfunction

    initial begin
        int lat, bubbles, exp_lat;
        logic stale;
        logic [1:0] op;
        logic [7:0] h, l, d;
        logic [17:0] exp8;

        reset = 1'b0;
        bus32.req_valid = 1'b0; bus32.req_op = 2'd0; bus32.req_hi = '0; bus32.req_lo = '0;
        bus32.req_operand = '0; bus32.resp_ready = 1'b0;
        bus8.req_valid = 1'b0; bus8.req_op = 2'd0; bus8.req_hi = '0; bus8.req_lo = '0;
        bus8.req_operand = '0; bus8.resp_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge clock); #1;
        checkOutput("reset ready/valid/dz/ovf",
                    {60'b0, bus32.req_ready, bus32.resp_valid, bus32.resp_dz, bus32.resp_ovf}, 64'b1000);
        checkOutput("reset hi/lo", {bus32.resp_hi, bus32.resp_lo}, 64'h0);
        @(negedge clock); reset = 1'b1;
        @(negedge clock);
        checkOutput("post-reset ready", {63'b0, bus32.req_ready}, 64'd1);

        // MUL -3 x 7
        applyStimulus(2'd0, 32'h0, 32'hFFFFFFFD, 32'd7, lat, bubbles);
        checkResp32("mul -3x7", lat, 17, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 1'b0);

        // Backpressure: response held for five cycles
        for (int i = 0; i < 5; i++) begin
            @(posedge clock); #1;
            checkOutput("hold valid/ready/dz/ovf",
                        {60'b0, bus32.resp_valid, bus32.req_ready, bus32.resp_dz, bus32.resp_ovf}, 64'b1000);
            checkOutput("hold hi/lo", {bus32.resp_hi, bus32.resp_lo}, 64'hFFFFFFFF_FFFFFFEB);
        end
        bus32.resp_ready = 1'b1;
        @(posedge clock); #1;
        bus32.resp_ready = 1'b0;
        checkOutput("release valid/ready", {62'b0, bus32.resp_valid, bus32.req_ready}, 64'b01);
        checkOutput("release hi/lo kept", {bus32.resp_hi, bus32.resp_lo}, 64'hFFFFFFFF_FFFFFFEB);

        // Back-to-back with resp_ready held
        bus32.resp_ready = 1'b1;
        applyStimulus(2'd2, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, bubbles);
        checkResp32("mulu max", lat, 17, 32'hFFFFFFFE, 32'h00000001, 1'b0, 1'b0);
        applyStimulus(2'd0, 32'h0, 32'h80000000, 32'h80000000, lat, bubbles);
        checkOutput("b2b bubble", 64'(bubbles), 64'd1);
        checkResp32("mul minxmin", lat, 17, 32'h40000000, 32'h00000000, 1'b0, 1'b0);

        // Divides
        applyStimulus(2'd1, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'd2, lat, bubbles);
        checkResp32("div -7/2", lat, 34, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 1'b0);
        applyStimulus(2'd3, 32'h0, 32'd100, 32'd7, lat, bubbles);
        checkResp32("divu 100/7", lat, 34, 32'd2, 32'd14, 1'b0, 1'b0);
        applyStimulus(2'd1, 32'h0, 32'd100, 32'hFFFFFFF9, lat, bubbles);
        checkResp32("div 100/-7", lat, 34, 32'd2, 32'hFFFFFFF2, 1'b0, 1'b0);

        // Divide by zero, then flags clear while data is kept
        applyStimulus(2'd1, 32'h12, 32'h34, 32'h0, lat, bubbles);
        checkResp32("div by zero", lat, 1, 32'h12, 32'h34, 1'b1, 1'b0);
        @(posedge clock); #1;
        checkOutput("dz cleared", {61'b0, bus32.resp_valid, bus32.resp_dz, bus32.resp_ovf}, 64'b0);
        checkOutput("dz data kept", {bus32.resp_hi, bus32.resp_lo}, {32'h12, 32'h34});

        // Overflow cases
        applyStimulus(2'd3, 32'd5, 32'd0, 32'd5, lat, bubbles);
        checkResp32("divu ovf", lat, 34, 32'd5, 32'd0, 1'b0, 1'b1);
        applyStimulus(2'd1, 32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFF, lat, bubbles);
        checkResp32("div min/-1 ovf", lat, 34, 32'hFFFFFFFF, 32'h80000000, 1'b0, 1'b1);

        // Reset in the middle of a divide
        @(posedge clock); #1;
        bus32.req_op = 2'd3; bus32.req_hi = 32'h0; bus32.req_lo = 32'd1000; bus32.req_operand = 32'd3;
        bus32.req_valid = 1'b1;
        @(posedge clock); #1;
        bus32.req_valid = 1'b0;
        repeat (10) @(posedge clock);
        #1 reset = 1'b0;
        #1;
        checkOutput("mid-op reset flags",
                    {60'b0, bus32.req_ready, bus32.resp_valid, bus32.resp_dz, bus32.resp_ovf}, 64'b1000);
        checkOutput("mid-op reset hi/lo", {bus32.resp_hi, bus32.resp_lo}, 64'h0);
        @(negedge clock); reset = 1'b1;
        stale = 1'b0;
        repeat (45) begin
            @(posedge clock); #1;
            if (bus32.resp_valid === 1'b1) stale = 1'b1;
        end
        checkOutput("no stale response", {63'b0, stale}, 64'd0);
        applyStimulus(2'd2, 32'h0, 32'd3, 32'd5, lat, bubbles);
        checkResp32("mulu 3x5 after reset", lat, 17, 32'd0, 32'd15, 1'b0, 1'b0);

        // Randomised 8-bit sweep against the integer reference
        for (int i = 0; i < 2000; i++) begin
            op = 2'($urandom_range(0, 3));
            l  = 8'($urandom);
            d  = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom);
            h  = 8'($urandom);
            if (op[0] && $urandom_range(0, 1) == 1) begin
                if (!op[1]) h = {8{l[7]}};
                else        h = (d == 8'd0) ? 8'd0 : 8'($urandom_range(0, int'(d) - 1));
            end
            applySmall(op, h, l, d, lat);
            exp8    = refModel(op, h, l, d);
            exp_lat = !op[0] ? 5 : (d == 8'd0) ? 1 : 10;
            checkOutput("rand8 result", {46'b0, bus8.resp_hi, bus8.resp_lo, bus8.resp_dz, bus8.resp_ovf},
                        {46'b0, exp8});
            checkOutput("rand8 latency", 64'(lat), 64'(exp_lat));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
